// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC generation, in-order instruction memory requests and a small
//            {pc, instr} FIFO feeding decode; redirects flush and discard.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsrc,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int            c_aw        = $clog2(DEPTH);
    localparam int            c_cw        = c_aw + 1;
    // Stale responses can accumulate across back-to-back redirects, so this
    // counter gets headroom beyond a single window of DEPTH requests.
    localparam int            c_sw        = c_cw + 3;
    localparam logic [c_cw:0] c_depth_occ = (c_cw + 1)'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_fifo_pc    [DEPTH];
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_cw-1:0] r_count;
    // Live in-flight requests only; stale ones are tracked in r_stale, so the
    // total outstanding count is r_live + r_stale.
    logic [c_cw-1:0] r_live;
    logic [c_sw-1:0] r_stale;
    logic [31:0]     r_pcq        [DEPTH];
    logic [c_aw-1:0] r_pcq_rd;
    logic [c_aw-1:0] r_pcq_wr;

    logic [c_cw:0]   w_occupancy;
    logic            w_issue;
    logic            w_grant;
    logic            w_resp_live;
    logic            w_resp_stale;
    logic            w_push;
    logic            w_valid;
    logic            w_pop;
    logic [c_sw-1:0] w_inflight;
    logic [c_sw-1:0] w_stale_redirect;
    logic            w_unused_target;

    always_comb begin
        w_occupancy      = {1'b0, r_count} + {1'b0, r_live};
        w_issue          = !rst && !pcsrc && (w_occupancy < c_depth_occ);
        w_grant          = w_issue && imem_gnt;
        w_resp_stale     = imem_rvalid && (r_stale != '0);
        w_resp_live      = imem_rvalid && (r_stale == '0);
        w_push           = w_resp_live && !pcsrc && !rst;
        w_valid          = !rst && (r_count != '0);
        w_pop            = w_valid && instr_ready;
        w_inflight       = r_stale + c_sw'(r_live);
        w_stale_redirect = w_inflight;
        if (imem_rvalid && (w_inflight != '0)) begin
            w_stale_redirect = w_inflight - c_sw'(1'b1);
        end
    end

    assign w_unused_target = ^target[1:0];

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = w_valid;
    assign instr       = r_fifo_instr[r_rd_ptr];
    assign instr_pc    = r_fifo_pc[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_stale    <= '0;
            r_pcq_rd   <= '0;
            r_pcq_wr   <= '0;
        end else if (pcsrc) begin
            // Everything in flight becomes stale; the PC queue restarts empty
            // because stale responses never need their address.
            r_fetch_pc <= {target[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_stale    <= w_stale_redirect;
            r_pcq_rd   <= '0;
            r_pcq_wr   <= '0;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_pcq_wr   <= r_pcq_wr + c_aw'(1'b1);
            end
            if (w_resp_stale) begin
                r_stale <= r_stale - c_sw'(1'b1);
            end
            if (w_push) begin
                r_pcq_rd <= r_pcq_rd + c_aw'(1'b1);
                r_wr_ptr <= r_wr_ptr + c_aw'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1'b1);
            end
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
            r_live  <= r_live + c_cw'(w_grant) - c_cw'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with a randomized memory model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] DMASK    = 32'hA5A5_A5A5;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        pcsrc       = 1'b0;
    logic [31:0] target      = 32'h0;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    logic [31:0] exp_pc     = RESET_PC;
    int          n_consumed = 0;

    // Memory model: grant delay 0..max_gd, response latency min_lat..max_lat
    int          max_gd   = 0;
    int          min_lat  = 1;
    int          max_lat  = 1;
    int          gnt_wait = 0;
    int          m_due;
    logic [31:0] rq_addr[$];
    int          rq_due[$];

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pcsrc       (pcsrc),
        .target      (target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (rst) begin
            rq_addr.delete();
            rq_due.delete();
            gnt_wait = 0;
        end else begin
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rq_addr[0] ^ DMASK;
                void'(rq_addr.pop_front());
                void'(rq_due.pop_front());
            end
            if (imem_req === 1'b1) begin
                if (gnt_wait == 0) begin
                    m_due = cyc + int'($urandom_range(max_lat, min_lat));
                    if (rq_due.size() > 0 && m_due < rq_due[$]) m_due = rq_due[$];
                    imem_gnt = 1'b1;
                    rq_addr.push_back(imem_addr);
                    rq_due.push_back(m_due);
                    gnt_wait = int'($urandom_range(max_gd, 0));
                end else begin
                    gnt_wait--;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        pcsrc       = 1'b0;
        target      = 32'h0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        exp_pc     = RESET_PC;
        n_consumed = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pcsrc = 1'b0; instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet: got req=%b valid=%b, want 0 0", imem_req, instr_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_request: got req=%b addr=%h valid=%b, want 1 %h 0",
                     imem_req, imem_addr, instr_valid, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        max_gd = 0; min_lat = 1; max_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (k < 2) begin
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency: cycle %0d valid=%b, want 0", k, instr_valid);
                end
            end else begin
                want = RESET_PC + 32'(4 * (k - 2));
                if (instr_valid !== 1'b1 || instr_pc !== want || instr !== (want ^ DMASK)) begin
                    errors++;
                    $display("FAIL stream_seq: cycle %0d got v=%b pc=%h i=%h, want 1 %h %h",
                             k, instr_valid, instr_pc, instr, want, want ^ DMASK);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        max_gd = 0; min_lat = 1; max_lat = 1;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            instr_ready = 1'b0;
            #2;
            if (k >= 2) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== (RESET_PC ^ DMASK)) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got v=%b pc=%h, want 1 %h", k, instr_valid, instr_pc, RESET_PC);
                end
            end
            checks++;
            if (imem_req !== (k < DEPTH)) begin
                errors++;
                $display("FAIL bp_req: cycle %0d got req=%b, want %b", k, imem_req, (k < DEPTH));
            end
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #2;
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL bp_order: got pc=%h i=%h, want %h %h", instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
        end
        checks++;
        if (n_consumed !== 20) begin
            errors++;
            $display("FAIL bp_gapless: got %0d consumed, want 20", n_consumed);
        end
    endtask

    task automatic test_redirect_midflight();
        int n_after = 0;
        max_gd = 0; min_lat = 3; max_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            pcsrc  = (k == 2);
            target = 32'h0000_0100;
            #2;
            if (k == 2) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_req_low: got req=%b, want 0", imem_req);
                end
            end
            if (k == 3) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
                    errors++;
                    $display("FAIL redir_addr: got req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
                end
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL redir_order: got pc=%h i=%h, want %h %h", instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                if (k > 2) n_after++;
            end
            if (pcsrc) exp_pc = {target[31:2], 2'b00};
        end
        pcsrc = 1'b0;
        checks++;
        if (n_after < 1) begin
            errors++;
            $display("FAIL redir_progress: got %0d instrs after redirect, want >=1", n_after);
        end
    endtask

    task automatic test_simultaneous();
        int n_after = 0;
        max_gd = 0; min_lat = 2; max_lat = 2;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            pcsrc  = (k == 3);
            target = 32'h0000_0302;
            #2;
            if (k == 3) begin
                checks++;
                if (instr_valid !== 1'b1 || imem_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_setup: got valid=%b rvalid=%b, want 1 1", instr_valid, imem_rvalid);
                end
            end
            if (k == 4) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL simul_flush: got valid=%b, want 0", instr_valid);
                end
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL simul_order: got pc=%h i=%h, want %h %h", instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                if (k > 3) n_after++;
            end
            if (pcsrc) exp_pc = {target[31:2], 2'b00};
        end
        pcsrc = 1'b0;
        checks++;
        if (n_after < 1) begin
            errors++;
            $display("FAIL simul_progress: got %0d instrs after redirect, want >=1", n_after);
        end
    endtask

    task automatic test_variable_latency();
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        max_gd = 3; min_lat = 1; max_lat = 4;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if (k > 0) @(negedge clk);
            instr_ready = ($urandom_range(0, 9) < 7);
            pcsrc       = ($urandom_range(0, 49) == 0);
            target      = $urandom;
            #2;
            if (prev_wait && !pcsrc) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL addr_hold: got req=%b addr=%h, want 1 %h", imem_req, imem_addr, prev_addr);
                end
            end
            prev_wait = (imem_req === 1'b1) && (imem_gnt === 1'b0);
            prev_addr = imem_addr;
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL rand_order: cycle %0d got pc=%h i=%h, want %h %h",
                             k, instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
            if (pcsrc) exp_pc = {target[31:2], 2'b00};
        end
        pcsrc = 1'b0;
        checks++;
        if (n_consumed < 100) begin
            errors++;
            $display("FAIL rand_progress: got %0d instrs, want >=100", n_consumed);
        end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] seen[$];
        logic [31:0] want_wrap [3];
        want_wrap[0] = 32'hFFFF_FFF8;
        want_wrap[1] = 32'hFFFF_FFFC;
        want_wrap[2] = 32'h0000_0000;
        max_gd = 0; min_lat = 1; max_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            pcsrc  = (k == 1);
            target = 32'hFFFF_FFFB;
            #2;
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL wrap_order: got pc=%h i=%h, want %h %h", instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                if (k > 1) seen.push_back(instr_pc);
            end
            if (pcsrc) exp_pc = {target[31:2], 2'b00};
        end
        pcsrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (seen.size() <= i) begin
                errors++;
                $display("FAIL wrap_seq: entry %0d missing, want %h", i, want_wrap[i]);
            end else if (seen[i] !== want_wrap[i]) begin
                errors++;
                $display("FAIL wrap_seq: entry %0d got %h, want %h", i, seen[i], want_wrap[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got req=%b valid=%b, want 0 0", imem_req, instr_valid);
        end
        @(negedge clk);
        rst        = 1'b0;
        exp_pc     = RESET_PC;
        n_consumed = 0;
        #2;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midrst_restart: got v=%b req=%b addr=%h, want 0 1 %h",
                     instr_valid, imem_req, imem_addr, RESET_PC);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #2;
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                checks++;
                if (instr_pc !== exp_pc || instr !== (exp_pc ^ DMASK)) begin
                    errors++;
                    $display("FAIL midrst_order: got pc=%h i=%h, want %h %h", instr_pc, instr, exp_pc, exp_pc ^ DMASK);
                end
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
        end
        checks++;
        if (n_consumed < 1) begin
            errors++;
            $display("FAIL midrst_progress: got %0d instrs after reset, want >=1", n_consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_midflight();
        test_simultaneous();
        test_variable_latency();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V CPU, sitting directly upstream of the control/decode stage. It holds the program counter and issues in-order word requests to instruction memory over a request/grant/response handshake. Returned instructions, tagged with their PC, go into a small FIFO that feeds decode over a valid/ready interface. A redirect (branch/jump taken, PCsrc asserted) flushes the FIFO, discards responses still in flight and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 2: FIFO entries and maximum outstanding memory requests, power of 2, ≥2.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pcsrc` in 1: redirect request, branch/jump taken.
- `target` in 32: redirect PC, sampled when `pcsrc`=1.
- `imem_req` out 1: memory request valid.
- `imem_addr` out 32: request word address (byte address, [1:0]=0).
- `imem_gnt` in 1: request accepted this cycle when `imem_req`=1.
- `imem_rvalid` in 1: response valid; responses arrive in request order, no earlier than the cycle after grant.
- `imem_rdata` in 32: response instruction.
- `instr` out 32: instruction to decode (bits [30:0] drive the control stage).
- `instr_pc` out 32: PC of `instr`.
- `instr_valid` out 1: `instr`/`instr_pc` valid.
- `instr_ready` in 1: decode consumes the head entry when `instr_valid`=1.

## Operation
- Registers:
  - `fetch_pc`: next address to request.
  - FIFO of {pc, instr}, `DEPTH` entries, with a `count` of occupied entries.
  - `outstanding`: granted requests not yet returned, including stale ones.
  - `stale`: in-flight responses to discard.
  - A PC queue, `DEPTH` deep, tagging each in-flight request with its address.
- Counter widths are $clog2(DEPTH)+1 bits.
- Issue rule: `imem_req` = !rst && !pcsrc && (count + outstanding − stale) < DEPTH. `imem_addr` = `fetch_pc`.
- On a grant with no redirect: push `fetch_pc` onto the PC queue, increment `outstanding`, and set `fetch_pc` += 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- On a response:
  - Pop the PC queue and decrement `outstanding`.
  - If `stale`>0, decrement `stale` and drop the data.
  - Otherwise push {popped pc, `imem_rdata`} into the FIFO.
  - The issue rule guarantees the FIFO is never full when a non-stale response arrives.
- Consume: `instr_valid`=1 && `instr_ready`=1 pops the head.
- Push and pop in the same cycle leave `count` unchanged.
- Redirect (`pcsrc`=1), applied at the clock edge:
  - `fetch_pc` ← {target[31:2], 2'b00}.
  - FIFO emptied (`count` ← 0).
  - `stale` ← the number of requests still in flight after this cycle's response.
  - `imem_req` is forced low in the redirect cycle, so no grant can occur.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is harmless.
- Redirect has priority over every other event.
- Back-to-back redirects: the last target wins and `stale` is recomputed each cycle.
- Redirect while `stale`>0: already-stale responses remain counted.
- No misalignment trap; target[1:0] are ignored.

## Timing
- Reset (synchronous, at the edge with `rst`=1):
  - `fetch_pc`=RESET_PC; `count`, `outstanding`, `stale` = 0.
  - `instr_valid`=0 and `imem_req`=0 while `rst`=1.
  - Responses arriving during or after reset for pre-reset requests are a system error.
  - Memory is reset together with this block.
- First request: `imem_req`=1 in the first cycle with `rst`=0.
- Latency: grant at cycle N, earliest `imem_rvalid` at N+1, `instr_valid`=1 at N+2. The FIFO output is registered, with no response-to-decode bypass.
- Throughput: with single-cycle memory and `instr_ready` held at 1, one instruction per cycle is sustained once the pipeline fills.
- Redirect at cycle R: `imem_req`=0 in R; a request to `target` is issued in R+1; the first target instruction reaches decode at R+3 or later.
- `instr_valid`/`instr`/`instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0. The exception is a redirect, which drops `instr_valid` at the next cycle.
- `imem_addr` is held stable while `imem_req`=1 and `imem_gnt`=0.

## Test plan
- Reset then stream: single-cycle memory returning `imem_rdata`=addr^32'hA5A5_A5A5, `instr_ready`=1 → `instr_pc` = 0, 4, 8, … on consecutive cycles from cycle 2, with data matching.
- Backpressure: `instr_ready`=0 for 10 cycles → after two valid entries, `imem_req` stays 0. After release, PCs continue without gap or duplicate.
- Redirect mid-flight: `pcsrc`=1 with `target`=32'h100 while 2 requests are outstanding → both responses are dropped, `imem_addr`=32'h100 the next cycle, and the first post-redirect `instr_pc`=32'h100.
- Simultaneous redirect, response and pop: all in one cycle → FIFO empty, `stale` counts only the remaining in-flight request, and the next valid PC is `target`.
- Variable latency: grants delayed 0–3 cycles at random and responses 1–4 cycles → `instr_pc` is strictly sequential, and `imem_addr` holds while ungranted.
- Wrap and reset mid-operation: redirect to 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0. Asserting `rst` mid-stream → `instr_valid`=0 the next cycle, and fetch restarts at RESET_PC.
